// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result valid-ready bundle for pipelined_adder.
interface pipelined_adder_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep sliced-carry adder/subtractor behind a valid/ready handshake.
// Define PIPELINED_ADDER_SAT_EN to clamp s to the signed range on overflow.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic clk,
  input logic rst_n,
  pipelined_adder_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  // x rotates right by one slice per stage: computed slices enter at the top, the
  // next a-slice to add sits at the bottom, so after STAGES stages x is the sum.
  logic [WIDTH-1:0] x_r [STAGES];
  logic [WIDTH-1:0] y_r [STAGES];
  logic             c_r [STAGES];
  logic             v_r [STAGES];
  logic             ovf_r;
  logic [WIDTH-1:0] xi  [STAGES];
  logic [WIDTH-1:0] yi  [STAGES];
  logic             ci  [STAGES];
  logic [SW:0]      sum [STAGES];
  logic [WIDTH-1:0] x_n [STAGES];
  logic [WIDTH-1:0] y_n [STAGES];
  logic             ovf_n;
  logic             adv;
  assign adv          = !v_r[STAGES-1] || bus.out_ready;
  assign bus.in_ready = adv;
  always_comb begin
    ovf_n = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      xi[k]  = k == 0 ? bus.a : x_r[k == 0 ? 0 : k - 1];
      yi[k]  = k == 0 ? bus.b ^ {WIDTH{bus.sub}} : y_r[k == 0 ? 0 : k - 1];
      ci[k]  = k == 0 ? bus.cin ^ bus.sub : c_r[k == 0 ? 0 : k - 1];
      sum[k] = {1'b0, xi[k][SW-1:0]} + {1'b0, yi[k][SW-1:0]} + {{SW{1'b0}}, ci[k]};
      x_n[k] = (xi[k] >> SW) | (WIDTH'(sum[k][SW-1:0]) << (WIDTH - SW));
      y_n[k] = yi[k] >> SW;
    end
    ovf_n = (xi[STAGES-1][SW-1] == yi[STAGES-1][SW-1]) &&
            (sum[STAGES-1][SW-1] != xi[STAGES-1][SW-1]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ovf_r <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_r[k] <= '0;
        y_r[k] <= '0;
        c_r[k] <= 1'b0;
        v_r[k] <= 1'b0;
      end
    end else if (adv) begin
      ovf_r <= ovf_n;
      for (int k = 0; k < STAGES; k++) begin
        x_r[k] <= x_n[k];
        y_r[k] <= y_n[k];
        c_r[k] <= sum[k][SW];
        v_r[k] <= k == 0 ? bus.in_valid : v_r[k == 0 ? 0 : k - 1];
      end
    end
  assign bus.out_valid = v_r[STAGES-1];
  assign bus.cout      = c_r[STAGES-1];
  assign bus.ovf       = ovf_r;
`ifdef PIPELINED_ADDER_SAT_EN
  // On overflow the raw MSB is the inverse of a's sign, which selects the clamp.
  assign bus.s = ovf_r ? {~x_r[STAGES-1][WIDTH-1], {(WIDTH-1){x_r[STAGES-1][WIDTH-1]}}}
                       : x_r[STAGES-1];
`else
  assign bus.s = x_r[STAGES-1];
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized backpressure checks for pipelined_adder (32 bits, 4 stages).
module tb_pipelined_adder;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [33:0] q [$];
  always #5 clk = ~clk;
  pipelined_adder_if #(.WIDTH(32)) bus ();
  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [31:0] OVP = 32'h7FFFFFFF;
  localparam logic [31:0] OVN = 32'h80000000;
`else
  localparam logic [31:0] OVP = 32'h80000000;
  localparam logic [31:0] OVN = 32'h7FFFFFFF;
`endif
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Reference: {ovf, cout, s} from true integer arithmetic on the operands.
  function automatic logic [33:0] model(input logic [31:0] a, b, input logic cin, sub);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint c  = longint'(cin);
    longint sv = sub ? sa - sb - c : sa + sb + c;
    longint uv = sub ? ua - ub - c : ua + ub + c;
    logic   co = sub ? (ua >= ub + c) : uv[32];
    logic   ov = sv > 64'sd2147483647 || sv < -64'sd2147483648;
    logic [31:0] s = uv[31:0];
`ifdef PIPELINED_ADDER_SAT_EN
    if (ov) s = sv > 0 ? 32'h7FFFFFFF : 32'h80000000;
`endif
    return {ov, co, s};
  endfunction
  task automatic directed(input string tag, input logic [31:0] a, b, input logic cin, sub,
                          input logic [31:0] s, input logic co, ov);
    int n;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = cin;
    bus.sub       = sub;
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    tick;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_s"}, 64'(bus.s), 64'(s));
    chk({tag, "_cout"}, 64'(bus.cout), 64'(co));
    chk({tag, "_ovf"}, 64'(bus.ovf), 64'(ov));
    tick;
    chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
  endtask
  task automatic rand_ops;
    bus.a   = $urandom;
    bus.b   = $urandom;
    bus.cin = 1'($urandom_range(0, 1));
    bus.sub = 1'($urandom_range(0, 1));
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    logic held = 1'b0;
    logic [33:0] hv = '0;
    logic [33:0] e;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    #2 rst_n = 1'b0;
    repeat (4) begin
      rand_ops;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_s", 64'(bus.s), 64'd0);
      chk("rst_cout", 64'(bus.cout), 64'd0);
      chk("rst_ovf", 64'(bus.ovf), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    repeat (6) begin
      tick;
      chk("idle_valid", 64'(bus.out_valid), 64'd0);
    end
    directed("ripple", 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    directed("ovf_pos", 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, OVP, 1'b0, 1'b1);
    directed("ovf_neg", 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, OVN, 1'b1, 1'b1);
    directed("sub_borrow", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    directed("sub_cin", 32'd7, 32'd5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0);
    while (got < 200 && cyc < 5000) begin
      rand_ops;
      bus.in_valid  = sent < 200 && $urandom_range(0, 99) < 70;
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) chk("stall_hold", 64'({bus.ovf, bus.cout, bus.s}), 64'(hv));
      if (bus.out_valid && bus.out_ready) begin
        e = q.size() != 0 ? q.pop_front() : 34'bx;
        chk("stream_res", 64'({bus.ovf, bus.cout, bus.s}), 64'(e));
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
      end
      held = bus.out_valid && !bus.out_ready;
      hv   = {bus.ovf, bus.cout, bus.s};
      tick;
      cyc++;
    end
    chk("stream_got", 64'(got), 64'd200);
    chk("stream_left", 64'(q.size()), 64'd0);
    bus.out_ready = 1'b0;
    repeat (3) begin
      rand_ops;
      bus.in_valid = 1'b1;
      tick;
    end
    bus.in_valid = 1'b0;
    tick;
    chk("mid_full", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_s", 64'(bus.s), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) begin
      tick;
      chk("mid_ghost", 64'(bus.out_valid), 64'd0);
    end
    directed("post_rst", 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
